// File: rtl/sliding_window_gen.sv
// K_S x K_S sliding window generator over a raster pixel stream. Emits a registered,
// stride-aligned window tagged with output-map coordinates, plus an end-of-frame pulse.
module sliding_window_gen #(
    parameter int K_S    = 3,
    parameter int N_COLS = 34,
    parameter int N_ROWS = 34,
    parameter int DW     = 1,
    parameter int STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DW-1:0]             stream_in,
    input  logic                      stream_in_en,
    output logic [K_S*K_S*DW-1:0]     window_out,
    output logic                      window_valid,
    output logic [$clog2(N_ROWS)-1:0] out_row,
    output logic [$clog2(N_COLS)-1:0] out_col,
    output logic                      frame_done
);

    localparam int BUF_N = (K_S - 1) * N_COLS + K_S;
    localparam int CW    = $clog2(N_COLS);
    localparam int RW    = $clog2(N_ROWS);
    localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
    localparam logic [CW-1:0] COL_K    = CW'(K_S - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(K_S - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(STRIDE - 1);

    logic [DW-1:0]         line_buf [BUF_N];
    logic [CW-1:0]         in_col;
    logic [CW-1:0]         win_col;
    logic [RW-1:0]         in_row;
    logic [RW-1:0]         win_row;
    logic [SW-1:0]         s_col;
    logic [SW-1:0]         s_row;
    logic [K_S*K_S*DW-1:0] win_p0;
    logic                  col_wrap;
    logic                  frame_end;
    logic                  legal;

    // Stride phase advance; restart realigns the phase at the first window position and at wrap.
    function automatic logic [SW-1:0] phase_next(input logic [SW-1:0] s, input logic restart);
        return (restart || s == S_LAST) ? '0 : s + 1'b1;
    endfunction

    assign col_wrap  = (in_col == COL_LAST);
    assign frame_end = col_wrap && (in_row == ROW_LAST);
    assign legal     = (in_row >= ROW_K) && (in_col >= COL_K) && (s_row == '0) && (s_col == '0);

    // Window as seen after the current pixel is shifted in: entry 0 is the incoming pixel itself.
    for (genvar j = 0; j < K_S; j++) begin : g_row
        for (genvar k = 0; k < K_S; k++) begin : g_col
            localparam int IDX = (K_S - 1 - j) * N_COLS + K_S - 1 - k;
            if (IDX == 0) begin : g_new
                assign win_p0[(j*K_S+k)*DW +: DW] = stream_in;
            end else begin : g_old
                assign win_p0[(j*K_S+k)*DW +: DW] = line_buf[IDX-1];
            end
        end
    end

    // Stage p0 -> output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_N; i++) line_buf[i] <= '0;
            in_col       <= '0;
            in_row       <= '0;
            s_col        <= '0;
            s_row        <= '0;
            win_col      <= '0;
            win_row      <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (stream_in_en) begin
                line_buf[0] <= stream_in;
                for (int i = 1; i < BUF_N; i++) line_buf[i] <= line_buf[i-1];
                in_col <= col_wrap ? '0 : in_col + 1'b1;
                s_col  <= phase_next(s_col, col_wrap || (in_col + 1'b1 == COL_K));
                if (col_wrap) begin
                    in_row  <= frame_end ? '0 : in_row + 1'b1;
                    s_row   <= phase_next(s_row, frame_end || (in_row + 1'b1 == ROW_K));
                    win_col <= '0;
                    // A row that produced windows advances the output-map row.
                    if (frame_end)
                        win_row <= '0;
                    else if (in_row >= ROW_K && s_row == '0)
                        win_row <= win_row + 1'b1;
                end else if (legal) begin
                    win_col <= win_col + 1'b1;
                end
                if (legal) begin
                    window_valid <= 1'b1;
                    window_out   <= win_p0;
                    out_row      <= win_row;
                    out_col      <= win_col;
                end
                frame_done <= frame_end;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen: 5x5 frames at stride 1 and 2 share one stream,
// and a default 34x34 1-bit instance is checked against a golden frame array.
module tb_sliding_window_gen;

    logic clk;
    logic rst;
    logic [7:0] s_in;
    logic s_en;
    logic s3_in;
    logic s3_en;

    logic [71:0] d1_win, d2_win;
    logic        d1_valid, d2_valid, d1_fd, d2_fd;
    logic [2:0]  d1_row, d1_col, d2_row, d2_col;
    logic [8:0]  d3_win;
    logic        d3_valid, d3_fd;
    logic [5:0]  d3_row, d3_col;

    int checks = 0;
    int errors = 0;

    logic [71:0] exp1, exp2;
    int er1, ec1, er2, ec2;
    int cnt1, cnt2, fdc1;
    logic [8:0] exp3;
    int er3, ec3, cnt3;
    bit g [34][34];

    sliding_window_gen #(.K_S(3), .N_COLS(5), .N_ROWS(5), .DW(8), .STRIDE(1)) d1 (
        .clk(clk), .reset(rst), .stream_in(s_in), .stream_in_en(s_en),
        .window_out(d1_win), .window_valid(d1_valid), .out_row(d1_row), .out_col(d1_col),
        .frame_done(d1_fd));

    sliding_window_gen #(.K_S(3), .N_COLS(5), .N_ROWS(5), .DW(8), .STRIDE(2)) d2 (
        .clk(clk), .reset(rst), .stream_in(s_in), .stream_in_en(s_en),
        .window_out(d2_win), .window_valid(d2_valid), .out_row(d2_row), .out_col(d2_col),
        .frame_done(d2_fd));

    sliding_window_gen d3 (
        .clk(clk), .reset(rst), .stream_in(s3_in), .stream_in_en(s3_en),
        .window_out(d3_win), .window_valid(d3_valid), .out_row(d3_row), .out_col(d3_col),
        .frame_done(d3_fd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel value: row/col nibbles, with frame tag bits in bit 7 and bit 3.
    function automatic logic [7:0] pv(input int f, input int r, input int c);
        return {f[0], r[2:0], f[1], c[2:0]};
    endfunction

    function automatic logic [71:0] build_win(input int f, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                w[(j*3+k)*8 +: 8] = pv(f, r - 2 + j, c - 2 + k);
        return w;
    endfunction

    task automatic pix(input int f, input int r, input int c);
        bit v1, v2, fd;
        @(negedge clk);
        s_in = pv(f, r, c);
        s_en = 1'b1;
        @(posedge clk);
        #1;
        s_en = 1'b0;
        v1 = (r >= 2 && c >= 2);
        v2 = v1 && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
        fd = (r == 4 && c == 4);
        if (v1) begin exp1 = build_win(f, r, c); er1 = r - 2; ec1 = c - 2; end
        if (v2) begin exp2 = build_win(f, r, c); er2 = (r - 2) / 2; ec2 = (c - 2) / 2; end
        chk("d1_valid", d1_valid, v1);
        chk("d1_window", d1_win, exp1);
        chk("d1_out_row", d1_row, er1);
        chk("d1_out_col", d1_col, ec1);
        chk("d1_frame_done", d1_fd, fd);
        chk("d2_valid", d2_valid, v2);
        chk("d2_window", d2_win, exp2);
        chk("d2_out_row", d2_row, er2);
        chk("d2_out_col", d2_col, ec2);
        chk("d2_frame_done", d2_fd, fd);
        cnt1 += int'(d1_valid);
        cnt2 += int'(d2_valid);
        fdc1 += int'(d1_fd);
    endtask

    task automatic idle();
        @(negedge clk);
        s_en = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_d1_valid", d1_valid, 1'b0);
        chk("idle_d2_valid", d2_valid, 1'b0);
        chk("idle_d1_frame_done", d1_fd, 1'b0);
        chk("idle_d1_window_hold", d1_win, exp1);
    endtask

    task automatic frame(input int f, input bit gapped);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                if (gapped)
                    for (int n = 0; n < 20 && $urandom_range(0, 99) >= 30; n++) idle();
                pix(f, r, c);
            end
    endtask

    task automatic clear_counts();
        cnt1 = 0; cnt2 = 0; fdc1 = 0;
    endtask

    task automatic pix3(input int r, input int c);
        bit v;
        @(negedge clk);
        s3_in = g[r][c];
        s3_en = 1'b1;
        @(posedge clk);
        #1;
        s3_en = 1'b0;
        v = (r >= 2 && c >= 2);
        if (v) begin
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++)
                    exp3[j*3+k] = g[r-2+j][c-2+k];
            er3 = r - 2;
            ec3 = c - 2;
        end
        chk("d3_valid", d3_valid, v);
        chk("d3_window", d3_win, exp3);
        chk("d3_out_row", d3_row, er3);
        chk("d3_out_col", d3_col, ec3);
        chk("d3_frame_done", d3_fd, (r == 33 && c == 33));
        cnt3 += int'(d3_valid);
    endtask

    initial begin
        rst = 1'b1; s_in = '0; s_en = 1'b0; s3_in = 1'b0; s3_en = 1'b0;
        exp1 = '0; exp2 = '0; exp3 = '0;
        er1 = 0; ec1 = 0; er2 = 0; ec2 = 0; er3 = 0; ec3 = 0; cnt3 = 0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_d1_window", d1_win, 72'h0);
        chk("reset_d1_valid", d1_valid, 1'b0);
        chk("reset_d1_row", d1_row, 3'd0);
        chk("reset_d1_col", d1_col, 3'd0);
        chk("reset_d1_frame_done", d1_fd, 1'b0);
        chk("reset_d2_window", d2_win, 72'h0);
        chk("reset_d3_window", d3_win, 9'h0);
        chk("reset_d3_valid", d3_valid, 1'b0);

        // Continuous frame with explicit checks on the first window.
        for (int i = 0; i < 13; i++) pix(0, i / 5, i % 5);
        chk("first_slot0", d1_win[7:0], 8'h00);
        chk("first_slot4", d1_win[39:32], 8'h11);
        chk("first_slot8", d1_win[71:64], 8'h22);
        chk("first_stride2_br", d2_win[71:64], 8'h22);
        for (int i = 13; i < 25; i++) pix(0, i / 5, i % 5);
        chk("cont_d1_windows", cnt1, 9);
        chk("cont_d2_windows", cnt2, 4);
        chk("cont_frame_done", fdc1, 1);

        // Gapped frame.
        clear_counts();
        frame(0, 1'b1);
        chk("gap_d1_windows", cnt1, 9);
        chk("gap_d2_windows", cnt2, 4);

        // Three back-to-back frames with distinct tags.
        clear_counts();
        frame(1, 1'b0);
        frame(2, 1'b0);
        frame(3, 1'b0);
        chk("b2b_d1_windows", cnt1, 27);
        chk("b2b_d2_windows", cnt2, 12);
        chk("b2b_frame_done", fdc1, 3);

        // Reset after the 17th pixel; the pixel presented with reset is discarded.
        for (int i = 0; i < 17; i++) pix(0, i / 5, i % 5);
        @(negedge clk);
        rst = 1'b1;
        s_in = pv(0, 3, 2);
        s_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_en = 1'b0;
        chk("rst_d1_window", d1_win, 72'h0);
        chk("rst_d1_valid", d1_valid, 1'b0);
        chk("rst_d1_row", d1_row, 3'd0);
        chk("rst_d1_col", d1_col, 3'd0);
        chk("rst_d1_frame_done", d1_fd, 1'b0);
        chk("rst_d2_window", d2_win, 72'h0);
        exp1 = '0; exp2 = '0; er1 = 0; ec1 = 0; er2 = 0; ec2 = 0;
        clear_counts();
        frame(2, 1'b0);
        chk("post_rst_d1_windows", cnt1, 9);
        chk("post_rst_d2_windows", cnt2, 4);
        chk("post_rst_frame_done", fdc1, 1);

        // Default configuration: random 34x34 bit frame.
        for (int r = 0; r < 34; r++)
            for (int c = 0; c < 34; c++)
                g[r][c] = bit'($urandom_range(0, 1));
        for (int r = 0; r < 34; r++)
            for (int c = 0; c < 34; c++)
                pix3(r, c);
        chk("d3_windows", cnt3, 1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
